wb_regfile: RTL
===============

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB control interface. Consumes the registered
//  mem_to_reg / reg_write controls and the MEM/WB data fields.
//  Selects the write-back value and commits it to a 32-entry register file.
//  Serves two combinational read ports to ID, with same-cycle write->read bypass.
//  Keeps a committed-write counter for debug and perf.
// PARAMETERS
//  DATA_W    32  register / datapath width
//  ADDR_W    5   register index width
//  NUM_REGS  32  register count (2**ADDR_W); entry 0 hardwired to zero
//  CNT_W     32  width of commit counter
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       asynchronous reset, active-low (0 = reset)
//  reg_write   in   1       MEM/WB write enable
//  mem_to_reg  in   2       MEM/WB write-back source select
//  wb_rd       in   ADDR_W  destination register index
//  alu_result  in   DATA_W  ALU result from MEM/WB
//  mem_rdata   in   DATA_W  load data from MEM/WB
//  pc_plus4    in   DATA_W  link value from MEM/WB
//  rs1_addr    in   ADDR_W  read port 1 index
//  rs2_addr    in   ADDR_W  read port 2 index
//  rs1_data    out  DATA_W  read port 1 data (combinational)
//  rs2_data    out  DATA_W  read port 2 data (combinational)
//  wb_data     out  DATA_W  selected write-back value (combinational, to forwarding)
//  wb_commit   out  1       registered: a write committed on the previous edge
//  commit_cnt  out  CNT_W   registered count of committed writes
// BEHAVIOUR
//  - Reset (rst=0, async): all registers cleared to 0.
//    wb_commit=0 and commit_cnt=0 immediately, with no clock required.
//    Bypass is disabled while rst=0, so rs*_data read 0.
//  - mem_to_reg select:
//      00 = alu_result
//      01 = mem_rdata
//      10 = pc_plus4
//      11 = reserved, selects alu_result
//  - Commit condition: rst=1 && reg_write=1 && wb_rd!=0.
//    Register write occurs on the rising edge of clk.
//  - Write to x0 is dropped: x0 unchanged, no commit pulse, counter unchanged.
//  - Reads: rsN_data = 0 if rsN_addr==0.
//    Otherwise, if the commit condition holds and wb_rd==rsN_addr, rsN_data = wb_data (bypass).
//    Otherwise rsN_data = stored value. Both ports are independent; same address on both is legal.
//  - wb_commit: 1-cycle latency. Equals the commit condition sampled at the previous edge.
//  - commit_cnt: increments by 1 per commit. Wraps from 2**CNT_W-1 to 0 with no flag.
//  - reg_write=1 with mem_to_reg=11 commits alu_result normally.
//  - Reset asserted mid-cycle: the pending write is lost.
//    Reset released: first write takes effect on the first rising edge with rst=1.
//  - Inputs are not re-registered; MEM/WB timing is owned upstream.
// STRUCTURE
//  - Shared package holds constants WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01,
//    WB_SEL_PC4=2'b10, WB_SEL_RSV=2'b11, plus DATA_W/ADDR_W defaults.
//    The MEM/WB control register and ID stage use the same package.
//  - One sub-module: wb_src_mux (combinational 4:1 select -> wb_data).
//  - Register array, bypass logic and counter are inline.
// TESTING
//  1. rst=0 pulse mid-run, no clk -> rs1_data=rs2_data=0, commit_cnt=0, wb_commit=0 at once.
//  2. reg_write=1, mem_to_reg=01, wb_rd=5, mem_rdata=0xDEADBEEF, rs1_addr=5, same cycle
//     -> rs1_data=0xDEADBEEF (bypass); next cycle stored value 0xDEADBEEF, wb_commit=1, commit_cnt=1.
//  3. reg_write=1, wb_rd=0, alu_result=0x1234, rs1_addr=0
//     -> rs1_data=0, then x0 stays 0, wb_commit=0, commit_cnt unchanged.
//  4. mem_to_reg=10, pc_plus4=0x00000040, wb_rd=31 -> x31=0x40.
//     Then mem_to_reg=11, alu_result=7, wb_rd=31 -> x31=7.
//  5. rs1_addr=rs2_addr=9 while writing x9=0xA5A5A5A5
//     -> both ports 0xA5A5A5A5. reg_write=0 same setup -> both return old x9.
//  6. Preload commit_cnt near max (force or CNT_W=4 instance): 16 commits -> wraps to 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared MEM/WB write-back definitions: source-select encodings and default widths.
// Also used by the MEM/WB control register and the ID stage.
package wb_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 32;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_RSV = 2'b11;

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source selector: picks ALU result, load data or link value.
// The reserved encoding falls back to the ALU result.
module wb_src_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] pc4_i,
    output logic [DATA_W-1:0] data_o
);

    // 4:1 write-back select; anything unexpected resolves to the ALU result
    always_comb begin
        data_o = alu_i;
        case (sel_i)
            WB_SEL_ALU: data_o = alu_i;
            WB_SEL_MEM: data_o = mem_i;
            WB_SEL_PC4: data_o = pc4_i;
            WB_SEL_RSV: data_o = alu_i;
            default:    data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file: selects the write-back value, commits it to
// a register array with x0 hardwired to zero, serves two read ports with
// same-cycle write->read bypass, and counts committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [1:0]        mem_to_reg,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [CNT_W-1:0]  commit_cnt
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              commit_s;
    logic              wb_commit_q;
    logic [CNT_W-1:0]  commit_cnt_q;
    logic [CNT_W-1:0]  commit_cnt_d;

    wb_src_mux #(
        .DATA_W (DATA_W)
    ) u_src_mux (
        .sel_i  (mem_to_reg),
        .alu_i  (alu_result),
        .mem_i  (mem_rdata),
        .pc4_i  (pc_plus4),
        .data_o (wb_data)
    );

    // Commit qualifier: writes to x0 and writes during reset are dropped
    always_comb begin
        if (rst && reg_write && (wb_rd != {ADDR_W{1'b0}})) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Next commit count, wrapping silently at the top of the counter range
    always_comb begin
        if (commit_s) begin
            commit_cnt_d = commit_cnt_q + CNT_W'(1);
        end else begin
            commit_cnt_d = commit_cnt_q;
        end
    end

    // Register array update; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            regs_q[wb_rd] <= wb_data;
        end else begin
            regs_q[wb_rd] <= regs_q[wb_rd];
        end
    end

    // Commit pulse and commit counter, both visible one cycle after the write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_commit_q  <= 1'b0;
            commit_cnt_q <= {CNT_W{1'b0}};
        end else begin
            wb_commit_q  <= commit_s;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign wb_commit  = wb_commit_q;
    assign commit_cnt = commit_cnt_q;

    // Read port 1: x0 reads zero, a same-cycle commit to the index is bypassed
    always_comb begin
        if (rs1_addr == {ADDR_W{1'b0}}) begin
            rs1_data = {DATA_W{1'b0}};
        end else if (commit_s && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    // Read port 2: same rules as port 1, fully independent
    always_comb begin
        if (rs2_addr == {ADDR_W{1'b0}}) begin
            rs2_data = {DATA_W{1'b0}};
        end else if (commit_s && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

endmodule
